// File: rtl/arm_regfile_mp.sv
// arm_regfile_mp: multi-port register file (R0..R14) for the ARM ID stage.
// NUM_RD combinational read ports, two write ports (wr1 wins on a same-address
// collision) and a per-register pending-write scoreboard for hazard stalls.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write data to the
// read ports; the default build returns stored contents only.
module arm_regfile_mp #(
    parameter int DW     = 32,
    parameter int DEPTH  = 15,
    parameter int AW     = 4,
    parameter int NUM_RD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [DW-1:0]        wr0_data,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [DW-1:0]        wr1_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [DEPTH-1:0]     busy_vec
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next register contents: wr0 applied first so wr1 overrides on a collision.
    // Addresses >= DEPTH never match any entry, so those writes drop out.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr0_en && wr0_addr == AW'(i)) mem_d[i] = wr0_data;
            if (wr1_en && wr1_addr == AW'(i)) mem_d[i] = wr1_data;
        end
    end

    // Next scoreboard: a write clears, an issue sets, and set wins over clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if ((wr0_en && wr0_addr == AW'(i)) || (wr1_en && wr1_addr == AW'(i)))
                busy_d[i] = 1'b0;
            if (iss_en && iss_addr == AW'(i))
                busy_d[i] = 1'b1;
        end
    end

    // State registers; reset loads each entry with its own index, scoreboard idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is built from flops, not RAM, so it can take per-entry reset values.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(i);
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            busy_q <= busy_d;
        end
    end

`ifdef WB_BYPASS_EN
    localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);
    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;
    assign wr0_ok = wr0_en && ({1'b0, wr0_addr} < DEPTH_A);
    assign wr1_ok = wr1_en && ({1'b0, wr1_addr} < DEPTH_A);
    assign iss_ok = iss_en && ({1'b0, iss_addr} < DEPTH_A);
`endif

    // Combinational read ports; out-of-range addresses read as zero and not busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr[k*AW +: AW] == AW'(i)) begin
                    rd_data[k*DW +: DW] = mem_q[i];
                    rd_busy[k]          = busy_q[i];
                end
            end
`ifdef WB_BYPASS_EN
            // Forward an in-flight write; wr1 over wr0, busy only if re-issued now.
            if (wr0_ok && wr0_addr == rd_addr[k*AW +: AW]) begin
                rd_data[k*DW +: DW] = wr0_data;
                rd_busy[k]          = iss_ok && iss_addr == rd_addr[k*AW +: AW];
            end
            if (wr1_ok && wr1_addr == rd_addr[k*AW +: AW]) begin
                rd_data[k*DW +: DW] = wr1_data;
                rd_busy[k]          = iss_ok && iss_addr == rd_addr[k*AW +: AW];
            end
`endif
        end
    end

    assign busy_vec = busy_q;

endmodule
